conv_result_unloader: RTL and testbench

//  Reader side of the convolution result buffer. The convolution engine writes one 4-bit
//  2x2 output result per SRAM word. This block reads those words back from a start address,

---
 rtl/conv_pkg.sv | 26 ++
 rtl/conv_result_unloader_packer.sv | 34 +++
 rtl/conv_result_unloader.sv | 111 +++++++++++
 tb/tb_conv_result_unloader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared constants, FSM state encoding and helpers for the conv result unloader.
// Optional build macro: RESULT_STATS_EN (adds the ones_total port).
package conv_pkg;
  localparam int ADDR_W  = 12;
  localparam int DATA_W  = 16;
  localparam int RES_W   = 4;
  localparam int PACK    = DATA_W / RES_W;
  localparam int RES_LSB = 0;
  localparam int SLOT_W  = $clog2(PACK) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CAPT  = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

  function automatic logic [2:0] res_ones(
    input logic [RES_W-1:0] v
  );
    res_ones = '0;
    for (int i = 0; i < RES_W; i++)
      res_ones = res_ones + 3'(v[i]);
  endfunction
endpackage

// File: rtl/conv_result_unloader_packer.sv
// Slot-indexed tile register: loads one result per slot, flags when full.
// Build macro RESULT_STATS_EN does not affect this block.
module result_packer
  import conv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [RES_W-1:0]  i_din,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);
  logic [DATA_W-1:0] r_data;
  logic [SLOT_W-1:0] r_slot;
  logic              w_at_last;
  logic              w_is_full;

  assign w_at_last = (r_slot == SLOT_W'(PACK - 1));
  assign w_is_full = (r_slot == SLOT_W'(PACK));
  // Look-ahead: full once the load in this cycle fills the top slot
  assign o_full = w_is_full || (i_ld && w_at_last);
  assign o_data = r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_data <= '0;
      r_slot <= '0;
    end else if (i_ld && !w_is_full) begin
      r_data[r_slot[SLOT_W-2:0]*RES_W +: RES_W] <= i_din;
      r_slot <= r_slot + SLOT_W'(1);
    end
  end
endmodule

// File: rtl/conv_result_unloader.sv
// Reads 4-bit results from SRAM and streams them as packed 16-bit tiles.
// Build macro RESULT_STATS_EN adds ones_total (1-bit count of the job).
module conv_result_unloader
  import conv_pkg::*;
(
  input  logic              clk,
  input  logic              reset_b,
  input  logic              go,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] num_results,
  output logic              busy,
  output logic [ADDR_W-1:0] dut_sram_read_address,
  output logic              dut_sram_read_enable,
  input  logic [DATA_W-1:0] sram_dut_read_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
`ifdef RESULT_STATS_EN
  ,
  output logic [ADDR_W+2:0] ones_total
`endif
);
  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_rem;
  logic              w_accept;
  logic              w_clr;
  logic              w_ld;
  logic              w_full;
  logic [DATA_W-1:0] w_pk_data;
  logic [RES_W-1:0]  w_res;
  logic              w_unused;

  assign w_res    = sram_dut_read_data[RES_LSB +: RES_W];
  assign w_unused = ^sram_dut_read_data[DATA_W-1:RES_W];
  assign w_accept = (r_state == IDLE) && go;
  assign w_ld     = (r_state == CAPT);
  // New tile starts on an accepted go or a handshake with results left
  assign w_clr    = w_accept ||
                    ((r_state == EMIT) && out_ready && (r_rem != '0));

  result_packer u_packer (
    .i_clk  (clk),
    .i_rst  (reset_b),
    .i_clr  (w_clr),
    .i_ld   (w_ld),
    .i_din  (w_res),
    .o_data (w_pk_data),
    .o_full (w_full)
  );

  always_ff @(posedge clk) begin
    if (reset_b) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_addr <= start_addr;
        r_rem  <= num_results;
      end else if (r_state == CAPT) begin
        r_addr <= r_addr + ADDR_W'(1);
        r_rem  <= r_rem - ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (go)
          w_next = (num_results == '0) ? DONE : FETCH;
      FETCH:
        w_next = CAPT;
      CAPT:
        w_next = (w_full || r_rem == ADDR_W'(1)) ? EMIT : FETCH;
      EMIT:
        if (out_ready)
          w_next = (r_rem == '0) ? DONE : FETCH;
      DONE:
        w_next = IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  assign busy                  = (r_state != IDLE);
  assign dut_sram_read_enable  = (r_state == FETCH);
  assign dut_sram_read_address =
    dut_sram_read_enable ? r_addr : '0;
  assign out_valid             = (r_state == EMIT);
  assign out_data              = out_valid ? w_pk_data : '0;
  assign out_last              = out_valid && (r_rem == '0);

`ifdef RESULT_STATS_EN
  logic [ADDR_W+2:0] r_ones;

  always_ff @(posedge clk) begin
    if (reset_b || w_accept)
      r_ones <= '0;
    else if (r_state == CAPT)
      r_ones <= r_ones + (ADDR_W+3)'(res_ones(w_res));
  end

  assign ones_total = r_ones;
`endif
endmodule

// File: tb/tb_conv_result_unloader.sv
// Scoreboard bench for conv_result_unloader: directed jobs, queued
// expected tiles/addresses, a forked monitor compares at negedge.
module tb_conv_result_unloader;
  logic        clk = 1'b0;
  logic        reset_b;
  logic        go;
  logic [11:0] start_addr;
  logic [11:0] num_results;
  logic        busy;
  logic [11:0] rd_addr;
  logic        rd_en;
  logic [15:0] rdata;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef RESULT_STATS_EN
  logic [14:0] ones_total;
`endif

  int checks   = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_valid  = 0;

  logic [15:0] mem [0:4095];
  logic [16:0] exp_q [$];
  logic [11:0] exp_a [$];

  always #5 clk = ~clk;

  always @(posedge clk)
    if (rd_en) rdata <= mem[rd_addr];

  conv_result_unloader dut (
    .clk                   (clk),
    .reset_b               (reset_b),
    .go                    (go),
    .start_addr            (start_addr),
    .num_results           (num_results),
    .busy                  (busy),
    .dut_sram_read_address (rd_addr),
    .dut_sram_read_enable  (rd_en),
    .sram_dut_read_data    (rdata),
    .out_data              (out_data),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .out_last              (out_last)
`ifdef RESULT_STATS_EN
    ,
    .ones_total            (ones_total)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic [16:0] e;
    logic [11:0] a;
    forever begin
      @(negedge clk);
      if (rd_en) begin
        n_strobe++;
        if (exp_a.size() == 0) begin
          chk("unexpected_strobe", {20'h0, rd_addr}, 32'hFFFF_FFFF);
        end else begin
          a = exp_a.pop_front();
          chk("read_addr", {20'h0, rd_addr}, {20'h0, a});
        end
      end
      if (out_valid) n_valid++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_tile", {16'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("tile_data", {16'h0, out_data}, {16'h0, e[15:0]});
          chk("tile_last", {31'h0, out_last}, {31'h0, e[16]});
        end
      end
    end
  endtask

  // vals: result i in nibble i; upper SRAM bits filled with junk
  task automatic setup(input logic [11:0] sa, input int n,
                       input logic [31:0] vals, input int na,
                       input int nt, input logic [15:0] t0,
                       input logic [15:0] t1);
    logic [11:0] a;
    for (int i = 0; i < n; i++) begin
      a = sa + 12'(i);
      mem[a] = 16'hBEE0 | {12'h0, vals[4*i +: 4]};
      if (i < na) exp_a.push_back(a);
    end
    if (nt > 0) exp_q.push_back({(nt == 1), t0});
    if (nt > 1) exp_q.push_back({1'b1, t1});
    start_addr  = sa;
    num_results = 12'(n);
  endtask

  task automatic go_pulse();
    @(posedge clk); #1;
    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_done"}, {31'h0, busy}, 32'h0);
    repeat (2) @(negedge clk);
    chk({nm, "_tiles_left"}, exp_q.size(), 32'h0);
    chk({nm, "_addrs_left"}, exp_a.size(), 32'h0);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_busy"},  {31'h0, busy},      32'h0);
    chk({nm, "_rden"},  {31'h0, rd_en},     32'h0);
    chk({nm, "_raddr"}, {20'h0, rd_addr},   32'h0);
    chk({nm, "_data"},  {16'h0, out_data},  32'h0);
    chk({nm, "_valid"}, {31'h0, out_valid}, 32'h0);
    chk({nm, "_last"},  {31'h0, out_last},  32'h0);
  endtask

  initial begin
    int base;
    int vbase;
    int k;
    int bcnt;
    reset_b     = 1'b1;
    go          = 1'b0;
    start_addr  = '0;
    num_results = '0;
    out_ready   = 1'b1;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
`ifdef RESULT_STATS_EN
    chk("reset_ones", {17'h0, ones_total}, 32'h0);
`endif
    reset_b = 1'b0;

    // 1: one full tile
    base = n_strobe;
    setup(12'h010, 4, 32'h0000_8421, 4, 1, 16'h8421, 16'h0);
    go_pulse();
    wait_idle("s1");
    chk("s1_strobes", n_strobe - base, 32'd4);

    // 2: full tile then partial tile
    setup(12'h020, 6, 32'h00C3_5A0F, 6, 2, 16'h5A0F, 16'h00C3);
    go_pulse();
    wait_idle("s2");
`ifdef RESULT_STATS_EN
    chk("s2_ones_total", {17'h0, ones_total}, 32'd12);
`endif

    // 3: backpressure holds the tile and stalls fetching
    @(posedge clk); #1;
    out_ready = 1'b0;
    setup(12'h010, 4, 32'h0000_8421, 4, 1, 16'h8421, 16'h0);
    go_pulse();
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("s3_valid_seen", {31'h0, out_valid}, 32'h1);
    base = n_strobe;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s3_hold_data", {16'h0, out_data}, 32'h8421);
      chk("s3_hold_valid", {31'h0, out_valid}, 32'h1);
    end
    chk("s3_no_strobe", n_strobe - base, 32'h0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_idle("s3");

    // 4: address wrap
    setup(12'hFFE, 4, 32'h0000_F731, 4, 1, 16'hF731, 16'h0);
    go_pulse();
    wait_idle("s4");

    // 5: empty job
    base  = n_strobe;
    vbase = n_valid;
    setup(12'h040, 0, 32'h0, 0, 0, 16'h0, 16'h0);
    go_pulse();
    bcnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      bcnt++;
      @(posedge clk); #1;
    end
    chk("s5_busy_cycles", bcnt, 32'd1);
    repeat (3) @(negedge clk);
    chk("s5_strobes", n_strobe - base, 32'h0);
    chk("s5_valids", n_valid - vbase, 32'h0);

    // 6: reset during CAPT of the second result
    setup(12'h080, 4, 32'h0000_4321, 2, 0, 16'h0, 16'h0);
    go_pulse();
    k = 0;
    bcnt = 0;
    while (bcnt < 2 && k < 50) begin
      @(negedge clk);
      if (rd_en) bcnt++;
      k++;
    end
    chk("s6_reached_second_fetch", bcnt, 32'd2);
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk); #1;
    chk_zero("s6_after_reset");
    reset_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("s6_addrs_left", exp_a.size(), 32'h0);
    setup(12'h100, 4, 32'h0000_9642, 4, 1, 16'h9642, 16'h0);
    go_pulse();
    wait_idle("s6_clean");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
